// File: rtl/wdt_pkg.sv
// Shared encodings for the windowed watchdog: FSM state codes and fault codes.
package wdt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_FIRST     = 3'b001,
        ST_SECOND    = 3'b010,
        ST_RST_PULSE = 3'b011,
        ST_FAIL      = 3'b100
    } wdt_state_e;

    localparam logic [2:0] FLT_NONE    = 3'b000;
    localparam logic [2:0] FLT_EARLY   = 3'b001;
    localparam logic [2:0] FLT_TIMEOUT = 3'b010;
    localparam logic [2:0] FLT_CFG     = 3'b011;

endpackage

// File: rtl/wdt_prescaler.sv
// Window tick generator: divides CLK by PRESCALE while enabled, sync clear on window entry.
module wdt_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    // Free-running 0..PRESCALE-1 counter, restarted whenever a window is entered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/window_watchdog_ctrl.sv
// Windowed watchdog: closed first window, open second window, timed reset pulses,
// reset counting against a limit and a sticky fail state.
module window_watchdog_ctrl
    import wdt_pkg::*;
#(
    parameter int PRESCALE  = 1000,
    parameter int RST_PULSE = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INIT,
    input  logic       WDSRVC,
    input  logic [7:0] FWLEN,
    input  logic [7:0] SWLEN,
    input  logic [7:0] RST_LMT,
    output logic       SRVC_ACK,
    output logic       WDT_RST,
    output logic       WD_FAIL,
    output logic [2:0] FLT_CODE,
    output logic [2:0] WD_STATE,
    output logic [7:0] RST_CNT
);
    // Width sized for RST_PULSE+1 so a one-cycle pulse still gets a 1-bit counter.
    localparam int PW = $clog2(RST_PULSE + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);

    wdt_state_e    state_q, state_d;
    logic          wdsrvc_q, svc;
    logic          tick, in_window;
    logic [7:0]    fw_sh, sw_sh, tick_cnt;
    logic [PW-1:0] pulse_cnt;
    logic          pulse_done;
    logic          start_req, enter_first, enter_second, enter_rp;
    logic          flt_set;
    logic [2:0]    flt_new;

    logic          srvc_ack_d, wdt_rst_d, wd_fail_d;
    logic [2:0]    flt_code_d;
    logic [7:0]    rst_cnt_d;

    assign svc        = WDSRVC & ~wdsrvc_q;
    assign in_window  = (state_q == ST_FIRST) || (state_q == ST_SECOND);
    assign pulse_done = (pulse_cnt == PULSE_LAST);
    assign WD_STATE   = state_q;

    wdt_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (enter_first | enter_second),
        .en   (in_window),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; a (re)start request is resolved after the case so a zero
    // SWLEN turns it into a config fault no matter where it came from.
    always_comb begin
        state_d      = state_q;
        start_req    = 1'b0;
        enter_first  = 1'b0;
        enter_second = 1'b0;
        enter_rp     = 1'b0;
        flt_set      = 1'b0;
        flt_new      = FLT_NONE;
        case (state_q)
            ST_IDLE: begin
                if (INIT)
                    start_req = 1'b1;
            end
            ST_FIRST: begin
                if (!INIT) begin
                    state_d = ST_IDLE;
                end else if (svc) begin
                    state_d  = ST_RST_PULSE;
                    enter_rp = 1'b1;
                    flt_set  = 1'b1;
                    flt_new  = FLT_EARLY;
                end else if (tick_cnt == fw_sh) begin
                    state_d      = ST_SECOND;
                    enter_second = 1'b1;
                end
            end
            ST_SECOND: begin
                if (!INIT) begin
                    state_d = ST_IDLE;
                end else if (svc) begin
                    state_d     = ST_FIRST;
                    enter_first = 1'b1;
                end else if (tick_cnt == sw_sh) begin
                    state_d  = ST_RST_PULSE;
                    enter_rp = 1'b1;
                    flt_set  = 1'b1;
                    flt_new  = FLT_TIMEOUT;
                end
            end
            ST_RST_PULSE: begin
                if (pulse_done) begin
                    if ((RST_LMT != 8'd0) && (RST_CNT >= RST_LMT))
                        state_d = ST_FAIL;
                    else if (INIT)
                        start_req = 1'b1;
                    else
                        state_d = ST_IDLE;
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_IDLE;
        endcase
        if (start_req) begin
            if (SWLEN == 8'd0) begin
                state_d  = ST_RST_PULSE;
                enter_rp = 1'b1;
                flt_set  = 1'b1;
                flt_new  = FLT_CFG;
            end else begin
                state_d     = ST_FIRST;
                enter_first = 1'b1;
            end
        end
    end

    // Next values of the registered outputs, derived from the transition just decided.
    always_comb begin
        srvc_ack_d = svc;
        wdt_rst_d  = (state_d == ST_RST_PULSE) || (state_d == ST_FAIL);
        wd_fail_d  = (state_d == ST_FAIL);
        flt_code_d = flt_set ? flt_new : FLT_CODE;
        rst_cnt_d  = (enter_rp && (RST_CNT != 8'hFF)) ? RST_CNT + 8'd1 : RST_CNT;
    end

    // Output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            SRVC_ACK <= 1'b0;
            WDT_RST  <= 1'b0;
            WD_FAIL  <= 1'b0;
            FLT_CODE <= FLT_NONE;
            RST_CNT  <= 8'd0;
        end else begin
            SRVC_ACK <= srvc_ack_d;
            WDT_RST  <= wdt_rst_d;
            WD_FAIL  <= wd_fail_d;
            FLT_CODE <= flt_code_d;
            RST_CNT  <= rst_cnt_d;
        end
    end

    // Service-edge history, tracked in every state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            wdsrvc_q <= 1'b0;
        else
            wdsrvc_q <= WDSRVC;
    end

    // Window lengths are sampled once per FIRST entry so mid-window writes wait.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fw_sh <= 8'd0;
            sw_sh <= 8'd0;
        end else if (enter_first) begin
            fw_sh <= FWLEN;
            sw_sh <= SWLEN;
        end
    end

    // Ticks elapsed in the current window; saturates so it can never wrap to a match.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            tick_cnt <= 8'd0;
        else if (enter_first || enter_second)
            tick_cnt <= 8'd0;
        else if (tick && (tick_cnt != 8'hFF))
            tick_cnt <= tick_cnt + 8'd1;
    end

    // Reset pulse length counter; restarts on every pulse entry, including back-to-back.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            pulse_cnt <= '0;
        else if (enter_rp)
            pulse_cnt <= '0;
        else if ((state_q == ST_RST_PULSE) && !pulse_done)
            pulse_cnt <= pulse_cnt + 1'b1;
    end

endmodule

// File: tb/tb_window_watchdog_ctrl.sv
// Bench for window_watchdog_ctrl: cycle model from the behavioural rules plus directed pins.
module tb_window_watchdog_ctrl;
    localparam int PRESCALE  = 4;
    localparam int RST_PULSE = 3;
    localparam int M_IDLE = 0, M_FIRST = 1, M_SECOND = 2, M_PULSE = 3, M_FAIL = 4;

    logic       CLK, RST, INIT, WDSRVC;
    logic [7:0] FWLEN, SWLEN, RST_LMT;
    logic       SRVC_ACK, WDT_RST, WD_FAIL;
    logic [2:0] FLT_CODE, WD_STATE;
    logic [7:0] RST_CNT;

    int checks = 0;
    int failures = 0;

    window_watchdog_ctrl #(.PRESCALE(PRESCALE), .RST_PULSE(RST_PULSE)) dut (
        .CLK(CLK), .RST(RST), .INIT(INIT), .WDSRVC(WDSRVC),
        .FWLEN(FWLEN), .SWLEN(SWLEN), .RST_LMT(RST_LMT),
        .SRVC_ACK(SRVC_ACK), .WDT_RST(WDT_RST), .WD_FAIL(WD_FAIL),
        .FLT_CODE(FLT_CODE), .WD_STATE(WD_STATE), .RST_CNT(RST_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: window position is cycles-since-entry; expiry is when that equals PRESCALE*len.
    int m_state, m_k, m_fw, m_sw, m_cnt, m_flt, m_left;
    bit m_ack, m_prev;
    int n_state, n_k, n_fw, n_sw, n_cnt, n_flt, n_left, fcode;
    bit n_ack, svc_m, want_start, want_restart, want_fault;

    always_comb begin
        n_state = m_state; n_k = m_k + 1; n_fw = m_fw; n_sw = m_sw;
        n_cnt = m_cnt; n_flt = m_flt; n_left = m_left;
        svc_m = WDSRVC && !m_prev;
        n_ack = svc_m;
        want_start = 1'b0; want_restart = 1'b0; want_fault = 1'b0; fcode = 0;
        case (m_state)
            M_IDLE: want_start = INIT;
            M_FIRST: begin
                if (!INIT) n_state = M_IDLE;
                else if (svc_m) begin want_fault = 1'b1; fcode = 1; end
                else if (m_k == PRESCALE * m_fw) begin n_state = M_SECOND; n_k = 0; end
            end
            M_SECOND: begin
                if (!INIT) n_state = M_IDLE;
                else if (svc_m) want_restart = 1'b1;
                else if (m_k == PRESCALE * m_sw) begin want_fault = 1'b1; fcode = 2; end
            end
            M_PULSE: begin
                n_left = m_left - 1;
                if (m_left == 1) begin
                    if (int'(RST_LMT) != 0 && m_cnt >= int'(RST_LMT)) n_state = M_FAIL;
                    else if (INIT) want_start = 1'b1;
                    else n_state = M_IDLE;
                end
            end
            default: ;
        endcase
        if (want_start && SWLEN == 8'd0) begin
            want_fault = 1'b1; fcode = 3;
        end else if (want_start || want_restart) begin
            n_state = M_FIRST; n_fw = int'(FWLEN); n_sw = int'(SWLEN); n_k = 0;
        end
        if (want_fault) begin
            n_state = M_PULSE; n_flt = fcode; n_left = RST_PULSE;
            n_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
    end

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_state <= M_IDLE; m_k <= 0; m_fw <= 0; m_sw <= 0; m_cnt <= 0;
            m_flt <= 0; m_left <= 0; m_ack <= 1'b0; m_prev <= 1'b0;
        end else begin
            m_state <= n_state; m_k <= n_k; m_fw <= n_fw; m_sw <= n_sw; m_cnt <= n_cnt;
            m_flt <= n_flt; m_left <= n_left; m_ack <= n_ack; m_prev <= WDSRVC;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("m_state", int'(WD_STATE), m_state);
        chk("m_ack", int'(SRVC_ACK), int'(m_ack));
        chk("m_wdt_rst", int'(WDT_RST), (m_state == M_PULSE || m_state == M_FAIL) ? 1 : 0);
        chk("m_fail", int'(WD_FAIL), (m_state == M_FAIL) ? 1 : 0);
        chk("m_flt", int'(FLT_CODE), m_flt);
        chk("m_cnt", int'(RST_CNT), m_cnt);
    end

    task automatic adv(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, int'(WD_STATE), 0);
        chk({tag, "_ack"}, int'(SRVC_ACK), 0);
        chk({tag, "_wdt"}, int'(WDT_RST), 0);
        chk({tag, "_fail"}, int'(WD_FAIL), 0);
        chk({tag, "_flt"}, int'(FLT_CODE), 0);
        chk({tag, "_cnt"}, int'(RST_CNT), 0);
    endtask

    initial begin
        RST = 1'b1; INIT = 1'b0; WDSRVC = 1'b0;
        FWLEN = 8'd2; SWLEN = 8'd3; RST_LMT = 8'd0;
        #1 RST = 1'b0;
        adv(2);
        chk_all_zero("rst");
        RST = 1'b1;
        adv(1);
        INIT = 1'b1;
        // 1: service in 2nd tick of SECOND restarts FIRST
        adv(1);  chk("t1_first", int'(WD_STATE), 1);
        adv(8);  chk("t1_first_last", int'(WD_STATE), 1);
        adv(1);  chk("t1_second", int'(WD_STATE), 2);
        adv(5);  WDSRVC = 1'b1;
        adv(1);  chk("t1_restart", int'(WD_STATE), 1);
                 chk("t1_ack", int'(SRVC_ACK), 1);
                 chk("t1_flt", int'(FLT_CODE), 0);
        WDSRVC = 1'b0;
        adv(1);  chk("t1_ack_off", int'(SRVC_ACK), 0);
        // 2: service during FIRST is an early fault
        WDSRVC = 1'b1;
        adv(1);  chk("t2_state", int'(WD_STATE), 3);
                 chk("t2_wdt", int'(WDT_RST), 1);
                 chk("t2_flt", int'(FLT_CODE), 1);
                 chk("t2_cnt", int'(RST_CNT), 1);
        WDSRVC = 1'b0;
        adv(2);  chk("t2_wdt_last", int'(WDT_RST), 1);
        adv(1);  chk("t2_back_first", int'(WD_STATE), 1);
                 chk("t2_wdt_off", int'(WDT_RST), 0);
                 chk("t2_flt_hold", int'(FLT_CODE), 1);
        // 3: timeout 12 CLKs into SECOND
        adv(9);  chk("t3_second", int'(WD_STATE), 2);
        adv(12); chk("t3_second_last", int'(WD_STATE), 2);
        adv(1);  chk("t3_state", int'(WD_STATE), 3);
                 chk("t3_flt", int'(FLT_CODE), 2);
                 chk("t3_cnt", int'(RST_CNT), 2);
        RST_LMT = 8'd2;
        // 4: limit reached -> sticky FAIL
        adv(3);  chk("t4_state", int'(WD_STATE), 4);
                 chk("t4_fail", int'(WD_FAIL), 1);
                 chk("t4_wdt", int'(WDT_RST), 1);
        for (int i = 0; i < 3; i++) begin
            INIT = 1'b0; WDSRVC = 1'b1;
            adv(1);
            INIT = 1'b1; WDSRVC = 1'b0;
            adv(1);
        end
        chk("t4_state_hold", int'(WD_STATE), 4);
        chk("t4_flt_hold", int'(FLT_CODE), 2);
        chk("t4_cnt_hold", int'(RST_CNT), 2);
        chk("t4_wdt_hold", int'(WDT_RST), 1);
        // 5: boundaries
        RST = 1'b0;
        adv(1);  chk("t5_in_rst", int'(WD_STATE), 0);
        SWLEN = 8'd0; RST_LMT = 8'd0; INIT = 1'b1; FWLEN = 8'd2; WDSRVC = 1'b0;
        RST = 1'b1;
        adv(1);  chk("t5_cfg_state", int'(WD_STATE), 3);
                 chk("t5_cfg_flt", int'(FLT_CODE), 3);
                 chk("t5_cfg_cnt", int'(RST_CNT), 1);
                 chk("t5_cfg_wdt", int'(WDT_RST), 1);
        adv(3);  chk("t5_cfg_again", int'(WD_STATE), 3);
                 chk("t5_cfg_cnt2", int'(RST_CNT), 2);
        SWLEN = 8'd3; FWLEN = 8'd0;
        adv(3);  chk("t5_fw0_first", int'(WD_STATE), 1);
        adv(1);  chk("t5_fw0_second", int'(WD_STATE), 2);
        FWLEN = 8'd2;
        adv(12); chk("t5_sw_last", int'(WD_STATE), 2);
        WDSRVC = 1'b1;
        adv(1);  chk("t5_sw_edge_ok", int'(WD_STATE), 1);
                 chk("t5_sw_edge_flt", int'(FLT_CODE), 3);
                 chk("t5_sw_edge_cnt", int'(RST_CNT), 2);
        WDSRVC = 1'b0;
        adv(8);  chk("t5_fw_last", int'(WD_STATE), 1);
        WDSRVC = 1'b1;
        adv(1);  chk("t5_fw_edge_state", int'(WD_STATE), 3);
                 chk("t5_fw_edge_flt", int'(FLT_CODE), 1);
                 chk("t5_fw_edge_cnt", int'(RST_CNT), 3);
        WDSRVC = 1'b0;
        // 6: async reset in the middle of a pulse
        adv(1);  chk("t6_pulse", int'(WDT_RST), 1);
        RST = 1'b0;
        #1;
        chk_all_zero("t6_async");
        adv(1);
        RST = 1'b1;
        adv(1);  chk("t6_first", int'(WD_STATE), 1);
                 chk("t6_cnt", int'(RST_CNT), 0);
        adv(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
